jump_engine: RTL
================

Name: jump_engine

Overview:
Parametrised jump-physics engine for the runner game. It replaces the fixed-constant jump logic in the keyboard datapath. It takes a jump key level from the keyboard decoder plus game-state qualifiers from the control FSM. It produces the player's vertical position, signed velocity, and jump/apex/land status for the renderer and collision logic. Screen Y grows downward, so "up" means decreasing height.

Parameters:
CLOCK_FREQUENCY, 25000000, Clock rate in Hz.
TICKS_PER_SEC, 6, physics update rate; tick period DIV = CLOCK_FREQUENCY/TICKS_PER_SEC cycles.
H_WIDTH, 16, width of height and velocity.
GROUND, 110, resting height.
CEILING, 0, minimum allowed height.
V0, 8, launch velocity in pixels per tick, positive = upward.
GRAVITY, 1, velocity decrement per tick.

Ports:
Clock  input  1  system clock
reset  input  1  synchronous, active-low
enable  input  1  game-active qualifier (ld_game or calc_jump from control)
pause  input  1  freeze request
jump_key  input  1  jump key held level (space, 8'h29, decoded upstream)
height  output  H_WIDTH  current vertical position, unsigned
velocity  output  H_WIDTH  signed two's-complement velocity
jumping  output  1  high while airborne
apex  output  1  one-cycle pulse at top of arc
landed  output  1  one-cycle pulse on touchdown

Behaviour:
- Reset (reset=0 at a Clock edge) gives: height=GROUND, velocity=0, jumping=0, apex=0, landed=0, tick counter=0, state=GROUND_ST, key edge register=0. Reset mid-air aborts the jump immediately.
- Key edge detection:
  - jump_key is registered each cycle.
  - A press is jump_key=1 while the registered value is 0.
  - A held key never retriggers.
- States are GROUND_ST and AIR_ST.
- GROUND_ST:
  - On a press with enable=1 and pause=0, on the next edge: state=AIR_ST, jumping=1, velocity=V0, tick counter=DIV-1.
  - height does not change until the first tick, so latency is DIV cycles to the first height change.
- AIR_ST with pause=1: all registers hold, including the tick counter. Presses are ignored.
- AIR_ST with pause=0:
  - The tick counter decrements each cycle.
  - A tick occurs when the counter is 0; on that cycle the counter reloads to DIV-1.
- On each tick, compute nh = height - velocity in H_WIDTH+2 signed arithmetic, then apply exactly one branch:
  - Landing: if nh >= GROUND, then height=GROUND, velocity=0, jumping=0, landed=1 for one cycle, state=GROUND_ST.
  - Ceiling clamp: else if nh < CEILING, then height=CEILING, velocity=0.
  - Normal step: otherwise height=nh, velocity=velocity-GRAVITY.
- apex pulses for one cycle on the tick where velocity goes from >0 to <=0. The ceiling clamp also counts as an apex.
- Game abort: enable=0 while in AIR_ST returns the engine to the reset values on the next edge, with no landed pulse.
- Simultaneous events:
  - If a landing tick coincides with a press, the land takes priority.
  - The press is consumed and does not start a new jump.
  - A new jump needs a fresh rising edge.
- apex and landed are never high in the same cycle.

Optional Feature:
DOUBLE_JUMP_EN
- Defined: one extra press is accepted per airborne period while in AIR_ST with pause=0. It sets velocity=V0 and reloads the tick counter to DIV-1; height is unchanged. An air-jump-used flag blocks further air presses and is cleared on land, abort or reset. A second apex pulse is permitted.
- Undefined: presses in AIR_ST are ignored, and the flag logic is absent.

Test Plan:
1. Full arc (CLOCK_FREQUENCY=12, TICKS_PER_SEC=6, DIV=2, defaults otherwise):
   - Stimulus: press jump_key.
   - Ascent: height sequence 102,95,89,84,80,77,75,74, apex on the 74 tick.
   - Descent: 74,75,77,80,84,89,95,102, then 110 with landed on tick 17; velocity=0, jumping=0.
2. Held key:
   - Stimulus: hold jump_key for 40 cycles across the landing.
   - Response: exactly one jump, no relaunch.
3. Pause mid-air:
   - Stimulus: assert pause for 10 cycles at height=89.
   - Response: height, velocity and counter are frozen; after release the next tick yields 84 at the same phase.
4. Ceiling clamp (CEILING=100):
   - Stimulus: press jump_key.
   - Response: first tick height=102; second tick nh=95 is clamped to 100 with velocity=0 and apex=1; descent follows to land at 110.
5. Abort and reset:
   - Stimulus: drop enable at height=80; separately, pull reset low mid-air.
   - Response: both return height=110, jumping=0, with no landed pulse.
6. DOUBLE_JUMP_EN:
   - Stimulus: second press at height=84; then a third press.
   - Response: the second press sets velocity=8 and the next tick gives height=76; the third press is ignored.

Source files
------------

// File: rtl/jump_engine.sv
// jump_engine: tick-based jump physics (launch, gravity, ceiling clamp, landing) for the runner.
// Optional macro DOUBLE_JUMP_EN accepts one extra press per airborne period.
module jump_engine #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TICKS_PER_SEC   = 6,
  parameter int H_WIDTH         = 16,
  parameter int GROUND          = 110,
  parameter int CEILING         = 0,
  parameter int V0              = 8,
  parameter int GRAVITY         = 1
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               pause,
  input  logic               jump_key,
  output logic [H_WIDTH-1:0] height,
  output logic [H_WIDTH-1:0] velocity,
  output logic               jumping,
  output logic               apex,
  output logic               landed
);
  localparam int DIV = CLOCK_FREQUENCY / TICKS_PER_SEC;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = H_WIDTH + 2;
  localparam logic [CW-1:0]        RELOAD    = CW'(DIV - 1);
  localparam logic signed [SW-1:0] GROUND_S  = SW'(GROUND);
  localparam logic signed [SW-1:0] CEILING_S = SW'(CEILING);

  typedef enum logic {GROUND_ST, AIR_ST} state_t;

  state_t                     state;
  logic                       key_q;
  logic [CW-1:0]              tick_cnt;
  logic                       press;
  logic                       tick;
  logic                       air_active;
  logic                       land_evt;
  logic                       air_press;
  logic                       air_jump;
  logic signed [H_WIDTH-1:0]  vel_s;
  logic signed [H_WIDTH-1:0]  vel_next;
  logic signed [SW-1:0]       nh;
  logic                       vel_pos;
  logic                       vel_next_nonpos;

  assign press      = jump_key & ~key_q;
  assign tick       = (tick_cnt == '0);
  assign air_active = (state == AIR_ST) && enable && !pause;

  // Height math runs two bits wider so overshoot past ground or ceiling stays visible.
  assign vel_s    = $signed(velocity);
  assign vel_next = vel_s - $signed(H_WIDTH'(GRAVITY));
  assign nh       = $signed({2'b00, height}) - SW'(vel_s);

  assign vel_pos         = !vel_s[H_WIDTH-1] && (vel_s != '0);
  assign vel_next_nonpos = vel_next[H_WIDTH-1] || (vel_next == '0);

  assign land_evt = air_active && tick && (nh >= GROUND_S);
  assign air_jump = air_active && air_press && !land_evt;

`ifdef DOUBLE_JUMP_EN
  logic air_used;
  assign air_press = press & ~air_used;

  always_ff @(posedge Clock) begin
    if (!reset || state == GROUND_ST || !enable || land_evt)
      air_used <= 1'b0;
    else if (air_jump)
      air_used <= 1'b1;
  end
`else
  assign air_press = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state    <= GROUND_ST;
      key_q    <= 1'b0;
      tick_cnt <= '0;
      height   <= H_WIDTH'(GROUND);
      velocity <= '0;
      jumping  <= 1'b0;
      apex     <= 1'b0;
      landed   <= 1'b0;
    end else begin
      key_q  <= jump_key;
      apex   <= 1'b0;
      landed <= 1'b0;
      case (state)
        GROUND_ST: begin
          if (press && enable && !pause) begin
            state    <= AIR_ST;
            jumping  <= 1'b1;
            velocity <= H_WIDTH'(V0);
            tick_cnt <= RELOAD;
          end
        end
        AIR_ST: begin
          if (!enable) begin
            state    <= GROUND_ST;
            tick_cnt <= '0;
            height   <= H_WIDTH'(GROUND);
            velocity <= '0;
            jumping  <= 1'b0;
          end else if (!pause) begin
            if (land_evt) begin
              state    <= GROUND_ST;
              tick_cnt <= '0;
              height   <= H_WIDTH'(GROUND);
              velocity <= '0;
              jumping  <= 1'b0;
              landed   <= 1'b1;
            end else if (air_jump) begin
              velocity <= H_WIDTH'(V0);
              tick_cnt <= RELOAD;
            end else if (tick) begin
              tick_cnt <= RELOAD;
              if (nh < CEILING_S) begin
                height   <= H_WIDTH'(CEILING);
                velocity <= '0;
                apex     <= 1'b1;
              end else begin
                height   <= nh[H_WIDTH-1:0];
                velocity <= vel_next;
                apex     <= vel_pos && vel_next_nonpos;
              end
            end else begin
              tick_cnt <= tick_cnt - CW'(1);
            end
          end
        end
        default: state <= GROUND_ST;
      endcase
    end
  end
endmodule
